// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - configurable-framing UART receiver with valid/ready holding register
module uart_rx_framed #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_uart_rx,
   input  logic [15:0]           i_baudrate_prescaler,
   input  logic [1:0]            i_parity_mode,
   input  logic                  i_two_stop,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_data_valid,
   input  logic                  i_data_ready,
   output logic                  o_parity_err,
   output logic                  o_frame_err,
   output logic                  o_overrun,
   output logic                  o_busy
);

   localparam int IDX_W = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
   } state_t;

   state_t                  state, next_state;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    rx;
   logic [15:0]             bit_cnt;
   logic [15:0]             prescale_q;
   logic [1:0]              parity_mode_q;
   logic                    two_stop_q;
   logic [DATA_WIDTH-1:0]   shift_q;
   logic [IDX_W-1:0]        bit_idx;
   logic                    stop_idx;
   logic                    parity_err_q;
   logic                    frame_err_q;

   logic sample, parity_en, last_data, last_stop, parity_bad, commit, accept;

   assign rx = sync_q[SYNC_STAGES-1];

   always_comb begin
      sample     = (bit_cnt == 16'd0);
      parity_en  = (parity_mode_q == 2'd1) || (parity_mode_q == 2'd2);
      last_data  = (bit_idx == IDX_W'(DATA_WIDTH-1));
      last_stop  = !two_stop_q || stop_idx;
      // Odd mode flags an even total count of ones; even mode flags an odd one.
      parity_bad = (^shift_q) ^ rx ^ (parity_mode_q == 2'd1);
      commit     = (state == S_STOP) && sample && last_stop;
      accept     = o_data_valid && i_data_ready;
      o_busy     = (state != S_IDLE);

      next_state = state;
      case (state)
         S_IDLE:       if (!rx) next_state = S_START;
         S_START:      if (sample) next_state = rx ? S_IDLE : S_DATA;
         S_DATA:       if (sample && last_data) next_state = parity_en ? S_PARITY : S_STOP;
         S_PARITY:     if (sample) next_state = S_STOP;
         S_STOP:       if (commit) next_state = rx ? S_IDLE : S_BREAK_WAIT;
         S_BREAK_WAIT: if (rx) next_state = S_IDLE;
         default:      next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= S_IDLE;
         sync_q        <= '1;
         bit_cnt       <= 16'd0;
         prescale_q    <= 16'd0;
         parity_mode_q <= 2'd0;
         two_stop_q    <= 1'b0;
         shift_q       <= '0;
         bit_idx       <= '0;
         stop_idx      <= 1'b0;
         parity_err_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         o_data        <= '0;
         o_data_valid  <= 1'b0;
         o_parity_err  <= 1'b0;
         o_frame_err   <= 1'b0;
         o_overrun     <= 1'b0;
      end else begin
         state  <= next_state;
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_uart_rx};

         // Framing configuration is frozen at start detection for the whole frame.
         if (state == S_IDLE) begin
            if (!rx) begin
               bit_cnt       <= i_baudrate_prescaler >> 1;
               prescale_q    <= i_baudrate_prescaler;
               parity_mode_q <= i_parity_mode;
               two_stop_q    <= i_two_stop;
               bit_idx       <= '0;
               stop_idx      <= 1'b0;
               parity_err_q  <= 1'b0;
               frame_err_q   <= 1'b0;
            end
         end else if (sample) begin
            bit_cnt <= prescale_q;
         end else begin
            bit_cnt <= bit_cnt - 16'd1;
         end

         if (sample) begin
            if (state == S_DATA) begin
               shift_q <= {rx, shift_q[DATA_WIDTH-1:1]};
               bit_idx <= bit_idx + 1'b1;
            end
            if (state == S_PARITY) parity_err_q <= parity_bad;
            if (state == S_STOP) begin
               stop_idx <= 1'b1;
               if (!rx) frame_err_q <= 1'b1;
            end
         end

         o_overrun <= commit && o_data_valid && !i_data_ready;

         if (commit && (!o_data_valid || i_data_ready)) begin
            o_data       <= shift_q;
            o_parity_err <= parity_err_q;
            o_frame_err  <= frame_err_q | ~rx;
            o_data_valid <= 1'b1;
         end else if (accept) begin
            o_data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - directed self-checking bench for uart_rx_framed
module tb_uart_rx_framed;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_uart_rx;
   logic [15:0] i_baudrate_prescaler;
   logic [1:0]  i_parity_mode;
   logic        i_two_stop;
   logic [7:0]  o_data;
   logic        o_data_valid;
   logic        i_data_ready;
   logic        o_parity_err;
   logic        o_frame_err;
   logic        o_overrun;
   logic        o_busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rises    = 0;
   int ovr_cnt  = 0;
   int rise_cyc = 0;
   int ovr_cyc  = 0;
   logic prev_valid = 1'b0;

   uart_rx_framed #(.DATA_WIDTH(8), .SYNC_STAGES(3)) dut (
      .i_clk                (i_clk),
      .i_reset              (i_reset),
      .i_uart_rx            (i_uart_rx),
      .i_baudrate_prescaler (i_baudrate_prescaler),
      .i_parity_mode        (i_parity_mode),
      .i_two_stop           (i_two_stop),
      .o_data               (o_data),
      .o_data_valid         (o_data_valid),
      .i_data_ready         (i_data_ready),
      .o_parity_err         (o_parity_err),
      .o_frame_err          (o_frame_err),
      .o_overrun            (o_overrun),
      .o_busy               (o_busy)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (o_data_valid && !prev_valid) begin
         rises++;
         rise_cyc = cyc;
      end
      if (o_overrun) begin
         ovr_cnt++;
         ovr_cyc = cyc;
      end
      prev_valid = o_data_valid;
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      i_uart_rx = b;
      repeat (16) tick();
   endtask

   // par < 0 means no parity bit on the wire
   task automatic send_frame(input logic [7:0] d, input int par, input int nstop, input logic s2);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (par >= 0) drive_bit(par[0]);
      drive_bit(1'b1);
      if (nstop == 2) drive_bit(s2);
   endtask

   task automatic consume();
      i_data_ready = 1'b1;
      tick();
      i_data_ready = 1'b0;
   endtask

   initial begin
      int k;
      int r0;
      int v0;

      i_reset              = 1'b1;
      i_uart_rx            = 1'b1;
      i_baudrate_prescaler = 16'd15;
      i_parity_mode        = 2'd0;
      i_two_stop           = 1'b0;
      i_data_ready         = 1'b0;
      repeat (3) tick();
      check("rst_data",  o_data, 0);
      check("rst_valid", o_data_valid, 0);
      check("rst_perr",  o_parity_err, 0);
      check("rst_ferr",  o_frame_err, 0);
      check("rst_ovr",   o_overrun, 0);
      check("rst_busy",  o_busy, 0);
      i_reset = 1'b0;
      repeat (5) tick();

      // 8N1 0xA5
      k = cyc; r0 = rises;
      send_frame(8'hA5, -1, 1, 1'b1);
      check("a5_rises", rises - r0, 1);
      check("a5_lat",   rise_cyc - k, 156);
      check("a5_data",  o_data, 8'hA5);
      check("a5_perr",  o_parity_err, 0);
      check("a5_ferr",  o_frame_err, 0);
      check("a5_busy",  o_busy, 0);
      consume();
      check("a5_clear", o_data_valid, 0);

      // 8E1 / 8O1 with 0x3C (four ones)
      i_parity_mode = 2'd2;
      k = cyc;
      send_frame(8'h3C, 1, 1, 1'b1);
      check("e_bad_lat",  rise_cyc - k, 172);
      check("e_bad_data", o_data, 8'h3C);
      check("e_bad_perr", o_parity_err, 1);
      consume();
      send_frame(8'h3C, 0, 1, 1'b1);
      check("e_ok_data", o_data, 8'h3C);
      check("e_ok_perr", o_parity_err, 0);
      check("e_ok_vld",  o_data_valid, 1);
      consume();
      i_parity_mode = 2'd1;
      send_frame(8'h3C, 0, 1, 1'b1);
      check("o_bad_perr", o_parity_err, 1);
      consume();
      send_frame(8'h3C, 1, 1, 1'b1);
      check("o_ok_perr", o_parity_err, 0);
      check("o_ok_vld",  o_data_valid, 1);
      consume();
      i_parity_mode = 2'd0;

      // false start: 5-clock glitch
      r0 = rises;
      i_uart_rx = 1'b0;
      repeat (5) tick();
      check("fs_busy_hi", o_busy, 1);
      i_uart_rx = 1'b1;
      repeat (40) tick();
      check("fs_busy_lo", o_busy, 0);
      check("fs_valid",   o_data_valid, 0);
      check("fs_rises",   rises - r0, 0);
      send_frame(8'h55, -1, 1, 1'b1);
      check("fs_55_data", o_data, 8'h55);
      check("fs_55_ferr", o_frame_err, 0);
      consume();

      // 8N2 with second stop low, then break held
      i_two_stop = 1'b1;
      k = cyc; r0 = rises;
      send_frame(8'h81, -1, 2, 1'b0);
      check("brk_lat",  rise_cyc - k, 172);
      check("brk_data", o_data, 8'h81);
      check("brk_ferr", o_frame_err, 1);
      consume();
      repeat (40 * 16) tick();
      check("brk_busy",   o_busy, 1);
      check("brk_valid",  o_data_valid, 0);
      check("brk_rises",  rises - r0, 1);
      i_uart_rx = 1'b1;
      repeat (10) tick();
      check("brk_idle",   o_busy, 0);
      check("brk_rises2", rises - r0, 1);
      i_two_stop = 1'b0;
      repeat (10) tick();

      // overrun: back-to-back with no consumer
      v0 = ovr_cnt;
      send_frame(8'h11, -1, 1, 1'b1);
      k = cyc;
      send_frame(8'h22, -1, 1, 1'b1);
      check("ovr_data", o_data, 8'h11);
      check("ovr_cnt",  ovr_cnt - v0, 1);
      check("ovr_cyc",  ovr_cyc - k, 156);
      check("ovr_vld",  o_data_valid, 1);
      consume();

      // ready raised on the commit cycle: new word replaces old, no overrun
      send_frame(8'h33, -1, 1, 1'b1);
      v0 = ovr_cnt;
      fork
         send_frame(8'h22, -1, 1, 1'b1);
         begin
            repeat (155) tick();
            i_data_ready = 1'b1;
            tick();
            i_data_ready = 1'b0;
         end
      join
      check("rdy_data", o_data, 8'h22);
      check("rdy_vld",  o_data_valid, 1);
      check("rdy_ovr",  ovr_cnt - v0, 0);

      // reset in the middle of a data bit, holding register still full
      i_uart_rx = 1'b0;
      repeat (16) tick();
      i_uart_rx = 1'b1;
      repeat (8) tick();
      i_reset = 1'b1;
      tick();
      check("mr_data",  o_data, 0);
      check("mr_valid", o_data_valid, 0);
      check("mr_busy",  o_busy, 0);
      check("mr_perr",  o_parity_err, 0);
      tick();
      i_reset = 1'b0;
      repeat (20) tick();
      check("mr_idle", o_busy, 0);
      k = cyc; r0 = rises;
      send_frame(8'hF0, -1, 1, 1'b1);
      check("mr_f0_rises", rises - r0, 1);
      check("mr_f0_lat",   rise_cyc - k, 156);
      check("mr_f0_data",  o_data, 8'hF0);
      check("mr_f0_ferr",  o_frame_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised, configurable-framing UART receiver. It oversamples a synchronised RX line with a programmable bit-period counter and validates the start bit at mid-bit. It supports optional odd/even parity and one or two stop bits, and reports parity, framing and overrun errors. Received words go out through a valid/ready holding register, so the downstream consumer (FIFO, bus bridge, softcore peripheral) can apply backpressure.

## Interface
- DATA_WIDTH, 8: data bits per frame (5..16), LSB first on the wire
- SYNC_STAGES, 3: flops in the RX input synchroniser (>=2)

- i_clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_uart_rx  in  1  asynchronous serial line, idle high
- i_baudrate_prescaler  in  16  P; bit period = P+1 clocks; externally registered; P>=3
- i_parity_mode  in  2  0 none, 1 odd, 2 even, 3 treated as none
- i_two_stop  in  1  1 = two stop bits checked
- o_data  out  DATA_WIDTH  received word, valid while o_data_valid
- o_data_valid  out  1  holding register full
- i_data_ready  in  1  consumer accepts word when valid&&ready
- o_parity_err  out  1  parity mismatch for word in o_data (qualified by valid)
- o_frame_err  out  1  a stop bit sampled 0 for word in o_data (qualified by valid)
- o_overrun  out  1  one-cycle strobe: completed word dropped because holding register full
- o_busy  out  1  high in any state other than IDLE

## Operation
- Line input passes through SYNC_STAGES flops. "rx" below means the synchronised value.
- Bit counter: loaded on entry to a state as specified. Each cycle: if 0, sample rx and reload P; else decrement.
- Mode latch: i_parity_mode, i_two_stop and P are captured on start detection and held for the whole frame.
- FSM:
  - IDLE: on rx==0, load counter with P>>1 and go to START.
  - START: at sample, if rx==1 it is a false start; go to IDLE with no output. Else go to DATA with bit index 0.
  - DATA: at each sample, shift rx in at the MSB (LSB-first). After DATA_WIDTH samples, go to PARITY if parity is enabled, else STOP.
  - PARITY: sample the parity bit. Odd mode: error if XOR(data, bit) == 0. Even mode: error if XOR(data, bit) == 1.
  - STOP: sample 1 or 2 (i_two_stop) stop bits. Any 0 sets frame_err. After the last stop sample, commit the word (see below). Then go to IDLE if the last stop sample was 1; if it was 0, go to BREAK_WAIT.
  - BREAK_WAIT: stay until rx==1, then go to IDLE. This stops a held-low break from retriggering.
- Commit:
  - Holding register empty, or being consumed this same cycle (valid&&ready): load o_data / o_parity_err / o_frame_err and set valid.
  - Otherwise: drop the word, pulse o_overrun, and leave the register unchanged.
- A word with errors is still delivered, with its flags set.
- o_data_valid clears on the cycle after valid&&ready, unless a commit happens in the same cycle.
- Reset: FSM to IDLE, counter 0, o_data 0, o_data_valid 0, o_parity_err 0, o_frame_err 0, o_overrun 0, o_busy 0, synchroniser flops 1.
- Reset mid-frame abandons the frame with no output. After reset, a line still low is seen as a start bit.

## Timing
- Detection cycle t: the first cycle the synchronised rx==0 in IDLE (SYNC_STAGES cycles after the pin edge).
- Start sample at t+(P>>1)+1. Each following sample is P+1 cycles later. Sample k (start = 0) is at t+(P>>1)+1+k(P+1).
- Final commit: o_data_valid rises 1 cycle after the final stop-bit sample. o_overrun pulses in that same cycle instead, if applicable.
- Return to IDLE on that same cycle, so a new start bit can be detected from the next cycle. Back-to-back frames with no idle time are supported.
- o_busy rises the cycle after detection and falls with the return to IDLE.
- Flags and o_data are stable while o_data_valid is high and i_data_ready is low.
- Prescaler changes mid-frame take effect only at the next start detection.

## Test plan
- 8N1, P=15, byte 0xA5 sent at 16 clk/bit:
  - o_data=0xA5, valid one cycle after the stop sample, flags 0.
  - i_data_ready=1 clears valid the next cycle.
- 8E1, P=15, 0x3C sent with parity bit 1 (wrong): o_data=0x3C, o_parity_err=1. Same byte with parity 0: o_parity_err=0. Repeat in odd mode with the polarities inverted.
- False start, P=15: 5-clock low glitch on the line → FSM returns to IDLE, no valid, no flags. A following good 0x55 frame is received correctly.
- 8N2 with the second stop bit 0, then line held low for 40 bits:
  - One word delivered with o_frame_err=1, then FSM sits in BREAK_WAIT.
  - Line releases high → IDLE; no spurious word is delivered.
- Overrun, i_data_ready=0: send 0x11 then 0x22 back-to-back → o_data stays 0x11 and o_overrun pulses exactly once, at the 0x22 commit. Raise ready on the commit cycle instead → 0x22 loads and no overrun.
- Reset asserted mid-data-bit of a frame: all outputs 0 next cycle, no word delivered. A following clean 0xF0 frame is received correctly.
